// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory-interface blocks: access size encodings,
// initiator state enumeration and the default MOC timeout.
package mem_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_GAP,
        ST_WRITE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/lane_align.sv
// Big-endian lane steering for a 32-bit memory word: extract-and-extend for
// loads and lane merge for partial stores. Purely combinational.
module lane_align
    import mem_if_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  s;
        logic signed [31:0] w;
        s = b;
        w = 32'(s);
        return sgn ? 32'(w) : {24'd0, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic sgn);
        logic signed [15:0] s;
        logic signed [31:0] w;
        s = h;
        w = 32'(s);
        return sgn ? 32'(w) : {16'd0, h};
    endfunction

    // Offset 0 is the most significant byte of the word.
    always_comb begin
        lane8 = word[7:0];
        case (offset)
            2'd0:    lane8 = word[31:24];
            2'd1:    lane8 = word[23:16];
            2'd2:    lane8 = word[15:8];
            default: lane8 = word[7:0];
        endcase
        lane16 = offset[1] ? word[15:0] : word[31:16];

        load_data = word;
        case (size)
            SZ_BYTE: load_data = extend8(lane8, is_signed);
            SZ_HALF: load_data = extend16(lane16, is_signed);
            default: load_data = word;
        endcase

        merge_data = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merge_data[31:24] = wdata[7:0];
                    2'd1:    merge_data[23:16] = wdata[7:0];
                    2'd2:    merge_data[15:8]  = wdata[7:0];
                    default: merge_data[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) merge_data[15:0]  = wdata;
                else           merge_data[31:16] = wdata;
            end
            default: merge_data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_initiator.sv
// MOV/MOC bus master for the byte-addressed big-endian memory. Serves one
// load/store at a time; byte/half stores are done as read-modify-write.
module mem_access_initiator
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              mov,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              moc
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state;
    logic [7:0]  tmo_cnt;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        illegal;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept  = req_valid & req_ready;
    assign illegal = (req_size == 2'd3)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'd0));

    lane_align u_lane_align (
        .word       (mem_rdata),
        .offset     (off_q),
        .size       (size_q),
        .is_signed  (signed_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Request fields are pure data and only need to be captured at accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            mov       <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        tmo_cnt   <= '0;
                        if (illegal) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_write && req_size == SZ_WORD) begin
                            state     <= ST_WRITE;
                            mov       <= 1'b1;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= ST_READ;
                            mov      <= 1'b1;
                            mem_read <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (moc) begin
                        mov      <= 1'b0;
                        mem_read <= 1'b0;
                        if (write_q) begin
                            state     <= ST_GAP;
                            mem_wdata <= merge_data;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_rdata <= load_data;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (tmo_cnt == TMO_LAST) begin
                            state     <= ST_RESP;
                            mov       <= 1'b0;
                            mem_read  <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                // One idle cycle so the responder sees a fresh rising MOV.
                ST_GAP: begin
                    state     <= ST_WRITE;
                    mov       <= 1'b1;
                    mem_write <= 1'b1;
                    tmo_cnt   <= '0;
                end
                ST_WRITE: begin
                    if (moc) begin
                        state     <= ST_RESP;
                        mov       <= 1'b0;
                        mem_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (tmo_cnt == TMO_LAST) begin
                            state     <= ST_RESP;
                            mov       <= 1'b0;
                            mem_write <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
